// File: rtl/mod_fold_89_pkg.sv
// Shared definitions for the 89-bit field datapath: modulus, widths, reducer
// state encoding and the fold-correction constant generator.
package mod_fold_89_pkg;

   localparam int W_RED  = 89;
   localparam int W_WIDE = 92;

   localparam logic [W_RED-1:0] P89 = 89'h19f393cffffffffffffffff;
   localparam logic [W_RED-1:0] C2  = 89'h60c6c30000000000000001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FOLD = 2'd1,
      CSUB = 2'd2,
      OUT  = 2'd3
   } state_t;

   // M*2^88 mod p by repeated subtraction; the quotient never exceeds 9.
   // Only ever called with constant arguments, so it folds to a constant.
   function automatic logic [W_RED-1:0] corr_value(input logic [3:0] m);
      logic [W_WIDE-1:0] v;
      v = {m, 88'b0};
      for (int i = 0; i < 10; i++) begin
         if (v >= {3'b000, P89}) begin
            v = v - {3'b000, P89};
         end
      end
      return v[W_RED-1:0];
   endfunction

endpackage

// File: rtl/mod_fold_89_corr.sv
// Fold-correction lookup: maps the overflow nibble M to (M * 2^88) mod p.
module mod_fold_89_corr
   import mod_fold_89_pkg::*;
(
   input  logic [3:0]       m,
   output logic [W_RED-1:0] corr
);

   logic [W_RED-1:0] table_q [16];

   for (genvar g = 0; g < 16; g++) begin : g_entry
      assign table_q[g] = corr_value(4'(g));
   end

   assign corr = table_q[m];

endmodule

// File: rtl/mod_fold_89.sv
// Sequential reducer: folds a 92-bit operand's overflow nibble back into the
// low bits, then does one conditional subtraction of p to reach the residue.
module mod_fold_89
   import mod_fold_89_pkg::*;
#(
   parameter int MAX_FOLDS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_WIDE-1:0] din,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W_RED-1:0]  dout,
   output logic [1:0]        fold_cnt,
   output logic              fold_err
);

   state_t            state_q, state_d;
   logic [W_WIDE-1:0] acc;
   logic [W_RED-1:0]  dout_r;
   logic [1:0]        fold_cnt_r;
   logic              fold_err_r;

   logic [W_RED-1:0]  corr;
   logic [W_WIDE-1:0] acc_folded;
   logic [W_RED-1:0]  acc_low;
   logic [W_RED-1:0]  acc_reduced;
   logic              need_fold;
   logic              do_fold;
   logic              overrun;

   mod_fold_89_corr u_corr (
      .m    (acc[91:88]),
      .corr (corr)
   );

   // Bit 88 alone is never folded: corr(1) = 2^88 would leave acc unchanged.
   assign need_fold  = (acc[91:89] != 3'b000);
   assign acc_folded = {4'b0000, acc[87:0]} + {3'b000, corr};

   assign acc_low     = acc[W_RED-1:0];
   assign acc_reduced = (acc_low >= P89) ? (acc_low - P89) : acc_low;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d = state_q;
      do_fold = 1'b0;
      overrun = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) state_d = FOLD;
         end
         FOLD: begin
            if (need_fold) begin
               if (int'(fold_cnt_r) >= MAX_FOLDS) begin
                  overrun = 1'b1;
                  state_d = CSUB;
               end else begin
                  do_fold = 1'b1;
               end
            end else begin
               state_d = CSUB;
            end
         end
         CSUB: state_d = OUT;
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it only takes effect on a clock edge.
      if (rst) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all
         // registers update together from pre-edge values.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         dout_r     <= '0;
         fold_cnt_r <= '0;
         fold_err_r <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            acc        <= din;
            fold_cnt_r <= '0;
         end
         if (do_fold) begin
            acc        <= acc_folded;
            fold_cnt_r <= fold_cnt_r + 2'd1;
         end
         // Sticky until reset so a rare overrun cannot be missed by software.
         if (overrun) begin
            fold_err_r <= 1'b1;
         end
         if (state_q == CSUB) begin
            dout_r <= acc_reduced;
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign dout      = dout_r;
   assign fold_cnt  = fold_cnt_r;
   assign fold_err  = fold_err_r;

endmodule

// File: tb/tb_mod_fold_89.sv
// Self-checking bench for mod_fold_89: directed corner values, backpressure,
// mid-operation reset and randomized operands against a bigint reference.
module tb_mod_fold_89;

   localparam logic [95:0] P     = 96'h19f393cffffffffffffffff;
   localparam logic [95:0] TWO88 = 96'd1 << 88;
   localparam logic [95:0] TWO89 = 96'd1 << 89;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [91:0] din;
   logic        out_valid;
   logic        out_ready;
   logic [88:0] dout;
   logic [1:0]  fold_cnt;
   logic        fold_err;

   int errors = 0;
   int checks = 0;

   mod_fold_89 #(.MAX_FOLDS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .fold_cnt  (fold_cnt),
      .fold_err  (fold_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [88:0] ref_mod(input logic [91:0] x);
      logic [95:0] r;
      r = {4'b0000, x} % P;
      return r[88:0];
   endfunction

   // Number of folds the reduction rule applies before the value drops below 2^89.
   function automatic int ref_folds(input logic [91:0] x);
      logic [95:0] v;
      logic [95:0] m;
      int n;
      v = {4'b0000, x};
      n = 0;
      while (v >= TWO89 && n < 8) begin
         m = v / TWO88;
         v = (v % TWO88) + ((m * TWO88) % P);
         n++;
      end
      return n;
   endfunction

   function automatic logic [91:0] rand92();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[91:0];
   endfunction

   // One full transaction; returns what was observed for extra directed checks.
   task automatic do_op(input logic [91:0] x, input int hold, input string tag,
                        output logic [88:0] got_dout, output logic [1:0] got_f,
                        output int got_lat);
      logic [88:0] exp_d;
      int          exp_f;
      int          lat;
      logic [88:0] held;
      exp_d = ref_mod(x);
      exp_f = ref_folds(x);
      got_dout = 'x;
      got_f    = 'x;
      got_lat  = -1;

      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready before accept: got %b expected 1", tag, in_ready);
      end
      in_valid = 1'b1;
      din      = x;
      @(negedge clk);
      in_valid = 1'b0;
      din      = rand92();

      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s out_valid timeout: got %b expected 1 within 20 cycles", tag, out_valid);
         return;
      end
      got_dout = dout;
      got_f    = fold_cnt;
      got_lat  = lat;

      checks++;
      if (lat != 3 + exp_f) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", tag, lat, 3 + exp_f);
      end
      checks++;
      if (dout !== exp_d) begin
         errors++;
         $display("FAIL %s dout: got %h expected %h (din %h)", tag, dout, exp_d, x);
      end
      checks++;
      if (int'(fold_cnt) != exp_f) begin
         errors++;
         $display("FAIL %s fold_cnt: got %0d expected %0d", tag, fold_cnt, exp_f);
      end
      checks++;
      if (fold_err !== 1'b0) begin
         errors++;
         $display("FAIL %s fold_err: got %b expected 0", tag, fold_err);
      end

      held = dout;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         din      = rand92();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || dout !== held || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s hold cycle %0d: got valid=%b dout=%h ready=%b expected valid=1 dout=%h ready=0",
                     tag, i, out_valid, dout, in_ready, held);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after handshake: got valid=%b ready=%b expected valid=0 ready=1",
                  tag, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== '0 ||
          fold_cnt !== 2'd0 || fold_err !== 1'b0) begin
         errors++;
         $display("FAIL reset state: got ready=%b valid=%b dout=%h cnt=%0d err=%b expected 1 0 0 0 0",
                  in_ready, out_valid, dout, fold_cnt, fold_err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_known();
      logic [91:0] vals [7];
      logic [88:0] exp_d [7];
      int          exp_f [7];
      logic [88:0] d;
      logic [1:0]  f;
      int          lat;
      logic [95:0] t;
      vals[0] = '0;                  exp_d[0] = '0;                           exp_f[0] = 0;
      t = P;         vals[1] = t[91:0]; exp_d[1] = '0;                           exp_f[1] = 0;
      t = P - 96'd1; vals[2] = t[91:0]; exp_d[2] = t[88:0];                      exp_f[2] = 0;
      t = TWO89;     vals[3] = t[91:0]; exp_d[3] = 89'h60c6c30000000000000001;   exp_f[3] = 1;
      t = TWO88 * 5; vals[4] = t[91:0]; exp_d[4] = 89'h2254490000000000000003;   exp_f[4] = 1;
      vals[5] = '1;                  exp_d[5] = ref_mod('1);                  exp_f[5] = -1;
      t = TWO89 - 96'd1; vals[6] = t[91:0]; t = TWO89 - 96'd1 - P; exp_d[6] = t[88:0]; exp_f[6] = 0;
      for (int i = 0; i < 7; i++) begin
         do_op(vals[i], 0, "known", d, f, lat);
         checks++;
         if (d !== exp_d[i]) begin
            errors++;
            $display("FAIL known[%0d] dout const: got %h expected %h", i, d, exp_d[i]);
         end
         checks++;
         if (exp_f[i] >= 0 ? (int'(f) != exp_f[i] || lat != 3 + exp_f[i]) : (f > 2'd3)) begin
            errors++;
            $display("FAIL known[%0d] folds/latency: got %0d/%0d expected %0d/%0d",
                     i, f, lat, exp_f[i], 3 + exp_f[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [88:0] d;
      logic [1:0]  f;
      int          lat;
      do_op(92'hfedcba9876543210fedcba9, 10, "backpressure", d, f, lat);
   endtask

   task automatic test_reset_mid_fold();
      logic seen;
      in_valid = 1'b1;
      din      = '1;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || fold_cnt !== 2'd0 || dout !== '0) begin
         errors++;
         $display("FAIL reset mid fold: got ready=%b valid=%b cnt=%0d dout=%h expected 1 0 0 0",
                  in_ready, out_valid, fold_cnt, dout);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset mid fold residue: got stray activity expected idle");
      end
   endtask

   task automatic test_random();
      logic [88:0] d;
      logic [1:0]  f;
      int          lat;
      logic [91:0] x;
      logic [95:0] t;
      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(0, 3))
            0: begin x = rand92(); x[91:89] = 3'b000; end
            1: begin t = P + 96'($urandom_range(0, 64)) - 96'd32; x = t[91:0]; end
            default: x = rand92();
         endcase
         do_op(x, int'($urandom_range(0, 3)), "random", d, f, lat);
      end
      checks++;
      if (fold_err !== 1'b0) begin
         errors++;
         $display("FAIL random fold_err: got %b expected 0", fold_err);
      end
   endtask

   initial begin
      test_reset();
      test_known();
      test_backpressure();
      test_reset_mid_fold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
